// File: rtl/fampiga_pll.sv
// rtl/fampiga_pll.sv - 28 MHz clock-enable, C1/C3/CCK phase, E-clock ring and core reset generator
module fampiga_pll #(
  parameter int ECLK_PHASES = 10
) (
  input  logic                   clk28m,
  input  logic                   reset_n,
  output logic                   clk7,
  output logic                   clk7_en,
  output logic                   c1,
  output logic                   c3,
  output logic                   cck,
  output logic [ECLK_PHASES-1:0] eclk,
  output logic                   rst_out_n
);

  localparam logic [2:0]             PH_INIT   = 3'b010;
  localparam logic [ECLK_PHASES-1:0] ECLK_INIT = {{(ECLK_PHASES-1){1'b0}}, 1'b1};

  logic [2:0] ph;
  logic [2:0] ph_next;
  logic       rst_meta;
  logic       rst_sync;

  assign ph_next = ph + 3'd1;

  // clk7 is a register bit of the phase counter, so it cannot glitch
  assign clk7 = ph[1];

  always_ff @(posedge clk28m or negedge reset_n) begin
    if (!reset_n) begin
      ph      <= PH_INIT;
      clk7_en <= 1'b1;
    end else begin
      ph      <= ph_next;
      clk7_en <= (ph[1:0] == 2'b00);
    end
  end

  // Quadrature phases are computed from the next count so they stay registered
  always_ff @(posedge clk28m or negedge reset_n) begin
    if (!reset_n) begin
      c1  <= 1'b0;
      c3  <= 1'b0;
      cck <= 1'b0;
    end else begin
      c1  <= ph_next[2];
      c3  <= ~(ph_next[2] ^ ph_next[1]);
      cck <= ph_next[2];
    end
  end

  always_ff @(posedge clk28m or negedge reset_n) begin
    if (!reset_n) begin
      eclk <= ECLK_INIT;
    end else if (clk7_en) begin
      eclk <= {eclk[ECLK_PHASES-2:0], eclk[ECLK_PHASES-1]};
    end
  end

  // Release waits for the synchronised reset and then a 7 MHz boundary
  always_ff @(posedge clk28m or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta  <= 1'b0;
      rst_sync  <= 1'b0;
      rst_out_n <= 1'b0;
    end else begin
      rst_meta  <= 1'b1;
      rst_sync  <= rst_meta;
      rst_out_n <= rst_out_n | (rst_sync & clk7_en);
    end
  end

endmodule

// File: tb/tb_fampiga_pll.sv
// tb/tb_fampiga_pll.sv - scoreboard bench for fampiga_pll with ECLK_PHASES 10 and 4
module tb_fampiga_pll;

  typedef struct {
    int         k;
    logic       clk7;
    logic       en;
    logic       c1;
    logic       c3;
    logic       cck;
    logic [9:0] eclk;
    logic [3:0] eclk4;
    logic       rst;
  } exp_t;

  logic       clk28m;
  logic       reset_n;
  logic       clk7, clk7_en, c1, c3, cck, rst_out_n;
  logic [9:0] eclk;
  logic       clk7_b, clk7_en_b, c1_b, c3_b, cck_b, rst_out_n_b;
  logic [3:0] eclk_b;

  int   tests;
  int   failed;
  exp_t exp_q[$];
  event chk_ev;

  fampiga_pll #(.ECLK_PHASES(10)) dut (
    .clk28m(clk28m), .reset_n(reset_n), .clk7(clk7), .clk7_en(clk7_en),
    .c1(c1), .c3(c3), .cck(cck), .eclk(eclk), .rst_out_n(rst_out_n)
  );

  fampiga_pll #(.ECLK_PHASES(4)) dut4 (
    .clk28m(clk28m), .reset_n(reset_n), .clk7(clk7_b), .clk7_en(clk7_en_b),
    .c1(c1_b), .c3(c3_b), .cck(cck_b), .eclk(eclk_b), .rst_out_n(rst_out_n_b)
  );

  initial clk28m = 1'b0;
  always #5 clk28m = ~clk28m;

  // Expected outputs k cycles after reset release (k = 0 is the reset state):
  // ph = 2+k; clk7_en sampled high at edges 1, 4, 8, 12, ...; rst_out_n rises at edge 4
  function automatic exp_t exp_at(int k);
    exp_t       e;
    logic [2:0] ph;
    int         rot;
    ph      = 3'((2 + k) % 8);
    rot     = ((k >= 1) ? 1 : 0) + k / 4;
    e.k     = k;
    e.clk7  = ph[1];
    e.en    = (k == 0) ? 1'b1 : (ph[1:0] == 2'b01);
    e.c1    = ph[2];
    e.c3    = ~(ph[2] ^ ph[1]);
    e.cck   = ph[2];
    e.eclk  = 10'd1 << (rot % 10);
    e.eclk4 = 4'd1 << (rot % 4);
    e.rst   = (k >= 4);
    return e;
  endfunction

  task automatic chk(input string name, input int k, input logic [9:0] got, input logic [9:0] want);
    tests++;
    if (got !== want) begin
      failed++;
      $display("FAIL %s k=%0d got=%0h want=%0h", name, k, got, want);
    end
  endtask

  always begin
    exp_t e;
    @(negedge clk28m or chk_ev);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("clk7", e.k, {9'd0, clk7}, {9'd0, e.clk7});
      chk("clk7_en", e.k, {9'd0, clk7_en}, {9'd0, e.en});
      chk("c1", e.k, {9'd0, c1}, {9'd0, e.c1});
      chk("c3", e.k, {9'd0, c3}, {9'd0, e.c3});
      chk("cck", e.k, {9'd0, cck}, {9'd0, e.cck});
      chk("eclk", e.k, eclk, e.eclk);
      chk("eclk_onehot", e.k, 10'($countones(eclk)), 10'd1);
      chk("rst_out_n", e.k, {9'd0, rst_out_n}, {9'd0, e.rst});
      chk("eclk4", e.k, {6'd0, eclk_b}, {6'd0, e.eclk4});
      chk("clk7_en4", e.k, {9'd0, clk7_en_b}, {9'd0, e.en});
      chk("rst_out_n4", e.k, {9'd0, rst_out_n_b}, {9'd0, e.rst});
    end
  end

  task automatic drain_check(input string name);
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL %s_drain got=%0d want=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Called in cycle 0 after its negedge: checks cycles first_k..last_k
  task automatic run_seq(input int first_k, input int last_k);
    for (int k = first_k; k <= last_k; k++) exp_q.push_back(exp_at(k));
    repeat (last_k - first_k + 1) @(negedge clk28m);
    #1;
    drain_check("run_seq");
  endtask

  // Called at negedge+1; reset is low for 2 time units, well under one cycle
  task automatic pulse_reset();
    #1 reset_n = 1'b0;
    #1;
    exp_q.push_back(exp_at(0));
    ->chk_ev;
    #1 reset_n = 1'b1;
    drain_check("async_reset");
  endtask

  initial begin
    tests   = 0;
    failed  = 0;
    reset_n = 1'b0;
    @(posedge clk28m);
    #2;
    for (int i = 0; i < 3; i++) exp_q.push_back(exp_at(0));
    repeat (3) @(negedge clk28m);
    #1;
    drain_check("reset_hold");
    #1 reset_n = 1'b1;
    run_seq(1, 200);
    pulse_reset();
    for (int o = 0; o < 4; o++) begin
      run_seq(1, 4 + o);
      pulse_reset();
    end
    run_seq(1, 48);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
